pwm_deadtime: RTL

Complementary output stage with dead-time insertion, placed directly downstream of the PWM generator in the ppwm core. It takes the single-ended `pwm_o` waveform, drives a high-side and a low-side gate signal, and guarantees break-before-make: the two outputs are never high together. Every switch is separated by a programmable number of cycles where both outputs are low. Pulses shorter than the dead time are swallowed and flagged.

---
 rtl/pwm_deadtime.sv | 118 +++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive with programmable break-before-make dead time.
// Latency: turn-off 1 cycle after pwm_i is sampled; turn-on D+1 cycles after turn-off.
// Backpressure: none; pwm_i is consumed every cycle, and pulses shorter than the dead time are swallowed and flagged.
//
// Ports:
//   clk, rst_n    - clock shared with the PWM generator; async active-low reset
//   enable_i      - 0 forces both drives low and parks the block in OFF
//   pwm_i         - single-ended PWM from the generator (same clock domain)
//   deadtime_i    - dead-time setting D; both sides stay low D+1 cycles per switch
//   pwm_hi_o      - high-side drive (registered)
//   pwm_lo_o      - low-side drive (registered)
//   dt_active_o   - high while a dead-time interval is in progress
//   glitch_o      - one-cycle pulse when a short input pulse is swallowed
module pwm_deadtime #(
  parameter int DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic                pwm_hi_o,
  output logic                pwm_lo_o,
  output logic                dt_active_o,
  output logic                glitch_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DT_HI = 3'd1,
    S_HIGH  = 3'd2,
    S_DT_LO = 3'd3,
    S_LOW   = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] CNT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_nxt_state;
  logic [DT_WIDTH-1:0] r_cnt;
  logic [DT_WIDTH-1:0] w_nxt_cnt;
  logic                w_glitch;

  // Next-state logic. deadtime_i is only looked at when a DT state is entered,
  // so a setting change mid-interval takes effect on the following switch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_glitch    = 1'b0;
    if (!enable_i) begin
      w_nxt_state = S_OFF;
    end else begin
      case (r_state)
        S_OFF: begin
          // Enabling always begins with a full dead-time interval.
          w_nxt_state = pwm_i ? S_DT_HI : S_DT_LO;
          w_nxt_cnt   = deadtime_i;
        end
        S_HIGH: begin
          if (!pwm_i) begin
            w_nxt_state = S_DT_LO;
            w_nxt_cnt   = deadtime_i;
          end
        end
        S_LOW: begin
          if (pwm_i) begin
            w_nxt_state = S_DT_HI;
            w_nxt_cnt   = deadtime_i;
          end
        end
        S_DT_HI: begin
          // Input fell back before the high side ever turned on: the low side
          // has been off throughout, so returning to it needs no dead time.
          if (!pwm_i) begin
            w_nxt_state = S_LOW;
            w_glitch    = 1'b1;
          end else if (r_cnt == '0) begin
            w_nxt_state = S_HIGH;
          end else begin
            w_nxt_cnt = r_cnt - CNT_ONE;
          end
        end
        S_DT_LO: begin
          if (pwm_i) begin
            w_nxt_state = S_HIGH;
            w_glitch    = 1'b1;
          end else if (r_cnt == '0) begin
            w_nxt_state = S_LOW;
          end else begin
            w_nxt_cnt = r_cnt - CNT_ONE;
          end
        end
        default: w_nxt_state = S_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register while still coming straight out of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      pwm_hi_o    <= 1'b0;
      pwm_lo_o    <= 1'b0;
      dt_active_o <= 1'b0;
      glitch_o    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      pwm_hi_o    <= (w_nxt_state == S_HIGH);
      pwm_lo_o    <= (w_nxt_state == S_LOW);
      dt_active_o <= (w_nxt_state == S_DT_HI) || (w_nxt_state == S_DT_LO);
      glitch_o    <= w_glitch;
    end
  end

endmodule
